ltsm_substate_sequencer: RTL and testbench



---
 rtl/ltsm_seq_pkg.sv | 17 +
 rtl/ltsm_stage_timer.sv | 37 +++
 rtl/ltsm_substate_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ltsm_substate_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltsm_seq_pkg.sv
// Shared types for the LTSM substate sequencer: FSM state encoding and
// fail-cause codes reported on o_fail_cause.
package ltsm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_RETRY,
    ST_DONE,
    ST_FAIL
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ERR     = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/ltsm_stage_timer.sv
// Saturating per-stage cycle counter; expired is high once the count
// reaches TIMEOUT_CYCLES-1 and stays there until cleared.
module ltsm_stage_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 800000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/ltsm_substate_sequencer.sv
// Walks NUM_STAGES substate engines in order with per-stage skip, timeout
// with bounded retry, and error abort; all outputs are registered.
module ltsm_substate_sequencer
  import ltsm_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 800000,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned IDX_W          = $clog2(NUM_STAGES)
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  i_start_en,
  input  logic [NUM_STAGES-1:0] i_stage_skip,
  input  logic [NUM_STAGES-1:0] i_stage_end,
  input  logic [NUM_STAGES-1:0] i_stage_err,
  output logic [NUM_STAGES-1:0] o_stage_start,
  output logic [IDX_W-1:0]      o_stage_idx,
  output logic [2:0]            o_retry_cnt,
  output logic                  o_done,
  output logic                  o_fail,
  output logic [IDX_W-1:0]      o_fail_stage,
  output logic [1:0]            o_fail_cause
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
  localparam logic [2:0]       MAX_RETRY_V = 3'(MAX_RETRY);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [2:0]            retry_q, retry_d;
  logic [NUM_STAGES-1:0] skip_q, skip_d;
  logic [IDX_W-1:0]      fstage_q, fstage_d;
  logic [1:0]            fcause_q, fcause_d;
  logic [NUM_STAGES-1:0] start_q, start_d;
  logic [IDX_W-1:0]      oidx_q;
  logic [2:0]            oretry_q;
  logic                  done_q, fail_q;
  logic                  advance, timer_expired, timer_clr, timer_en;

  ltsm_stage_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLK),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  assign timer_en  = (state_q == ST_RUN);
  assign timer_clr = (state_q != ST_RUN) || advance;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    skip_d   = skip_q;
    fstage_d = fstage_q;
    fcause_d = fcause_q;
    advance  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start_en) begin
          state_d  = ST_RUN;
          skip_d   = i_stage_skip;
          idx_d    = '0;
          retry_d  = '0;
          fstage_d = '0;
          fcause_d = CAUSE_NONE;
        end
      end
      ST_RUN: begin
        // Priority: abort, skip, error, end, timeout.
        if (!i_start_en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          retry_d = '0;
        end else if (skip_q[idx_q]) begin
          advance = 1'b1;
        end else if (i_stage_err[idx_q]) begin
          state_d  = ST_FAIL;
          fstage_d = idx_q;
          fcause_d = CAUSE_ERR;
        end else if (i_stage_end[idx_q]) begin
          advance = 1'b1;
        end else if (timer_expired) begin
          if (retry_q < MAX_RETRY_V) begin
            state_d = ST_RETRY;
          end else begin
            state_d  = ST_FAIL;
            fstage_d = idx_q;
            fcause_d = CAUSE_TIMEOUT;
          end
        end
      end
      ST_RETRY: begin
        retry_d = retry_q + 3'd1;
        state_d = ST_RUN;
      end
      ST_DONE, ST_FAIL: begin
        if (!i_start_en) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        retry_d = '0;
      end
    end
  end

  always_comb begin
    start_d = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      start_d[k] = (state_q == ST_RUN) && (idx_q == IDX_W'(k)) && !skip_q[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      retry_q  <= '0;
      skip_q   <= '0;
      fstage_q <= '0;
      fcause_q <= CAUSE_NONE;
      start_q  <= '0;
      oidx_q   <= '0;
      oretry_q <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      skip_q   <= skip_d;
      fstage_q <= fstage_d;
      fcause_q <= fcause_d;
      start_q  <= start_d;
      oidx_q   <= idx_q;
      oretry_q <= retry_q;
      done_q   <= (state_q == ST_DONE);
      fail_q   <= (state_q == ST_FAIL);
    end
  end

  assign o_stage_start = start_q;
  assign o_stage_idx   = oidx_q;
  assign o_retry_cnt   = oretry_q;
  assign o_done        = done_q;
  assign o_fail        = fail_q;
  assign o_fail_stage  = fstage_q;
  assign o_fail_cause  = fcause_q;

endmodule

// File: tb/tb_ltsm_substate_sequencer.sv
// Bench for ltsm_substate_sequencer: a stage-budget reference model predicts
// every output each cycle; directed scenarios pin the model with literals.
module tb_ltsm_substate_sequencer;

  localparam int N   = 6;
  localparam int TMO = 16;
  localparam int MR  = 2;
  localparam int IW  = 3;

  localparam int M_IDLE = 0, M_RUNNING = 1, M_GAP = 2, M_FINISHED = 3, M_FAILED = 4;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [N-1:0]  skip, s_end, s_err;
  logic [N-1:0]  o_start;
  logic [IW-1:0] o_idx, o_fstage;
  logic [2:0]    o_retry;
  logic          o_done, o_fail;
  logic [1:0]    o_cause;

  ltsm_substate_sequencer #(
    .NUM_STAGES    (N),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (MR)
  ) dut (
    .CLK          (clk),
    .rst          (rst),
    .i_start_en   (en),
    .i_stage_skip (skip),
    .i_stage_end  (s_end),
    .i_stage_err  (s_err),
    .o_stage_start(o_start),
    .o_stage_idx  (o_idx),
    .o_retry_cnt  (o_retry),
    .o_done       (o_done),
    .o_fail       (o_fail),
    .o_fail_stage (o_fstage),
    .o_fail_cause (o_cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a stage is granted a budget of TMO run cycles per attempt.
  int           m_mode = M_IDLE;
  int           m_stage = 0, m_tries = 0, m_budget = TMO, m_fstage = 0, m_fcause = 0;
  logic [N-1:0] m_skip = '0;
  logic [N-1:0] exp_start = '0;
  int           exp_idx = 0, exp_retry = 0;
  bit           exp_done = 0, exp_fail = 0, model_live = 0;

  task automatic m_leave_to_idle();
    m_mode  = M_IDLE;
    m_stage = 0;
    m_tries = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      exp_start = '0; exp_idx = 0; exp_retry = 0; exp_done = 0; exp_fail = 0;
      m_mode = M_IDLE; m_stage = 0; m_tries = 0; m_budget = TMO;
      m_skip = '0; m_fstage = 0; m_fcause = 0;
      model_live = 1;
    end else begin
      exp_start = '0;
      if (m_mode == M_RUNNING && !m_skip[m_stage]) exp_start[m_stage] = 1'b1;
      exp_done  = (m_mode == M_FINISHED);
      exp_fail  = (m_mode == M_FAILED);
      exp_idx   = m_stage;
      exp_retry = m_tries;
      case (m_mode)
        M_IDLE: if (en) begin
          m_mode = M_RUNNING; m_skip = skip; m_stage = 0; m_tries = 0;
          m_budget = TMO; m_fstage = 0; m_fcause = 0;
        end
        M_RUNNING: begin
          if (!en) m_leave_to_idle();
          else if (m_skip[m_stage] || (s_end[m_stage] && !s_err[m_stage])) begin
            if (m_stage == N - 1) m_mode = M_FINISHED;
            else begin m_stage++; m_tries = 0; m_budget = TMO; end
          end else if (s_err[m_stage]) begin
            m_mode = M_FAILED; m_fstage = m_stage; m_fcause = 1;
          end else if (m_budget == 1) begin
            if (m_tries < MR) m_mode = M_GAP;
            else begin m_mode = M_FAILED; m_fstage = m_stage; m_fcause = 2; end
          end else m_budget--;
        end
        M_GAP: begin m_tries++; m_budget = TMO; m_mode = M_RUNNING; end
        default: if (!en) m_leave_to_idle();
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("stage_start", 32'(o_start), 32'(exp_start));
      check("stage_idx", 32'(o_idx), exp_idx);
      check("retry_cnt", 32'(o_retry), exp_retry);
      check("done", 32'(o_done), 32'(exp_done));
      check("fail", 32'(o_fail), 32'(exp_fail));
      check("fail_stage", 32'(o_fstage), m_fstage);
      check("fail_cause", 32'(o_cause), m_fcause);
    end
  end

  // Stage responder policy.
  int           p_delay = 3, p_hang_stage = -1, p_hang_tries = 0, p_err_stage = -1;
  bit           p_noise = 0;
  int           act_cnt = 0, max_retry_seen = 0;
  logic [N-1:0] prev_start = '0;
  int           pulses[$];

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic cycle();
    int cur;
    @(negedge clk);
    cur = onehot_idx(exp_start);
    if (exp_start != '0 && exp_start != prev_start) pulses.push_back(cur);
    act_cnt = (exp_start == '0) ? 0 : ((exp_start == prev_start) ? act_cnt + 1 : 1);
    prev_start = exp_start;
    if (exp_retry > max_retry_seen) max_retry_seen = exp_retry;
    s_end = p_noise ? (N'($urandom) & ~exp_start) : '0;
    s_err = (p_noise && $urandom_range(0, 99) == 0) ? N'($urandom) : '0;
    if (p_noise) skip = N'($urandom);
    if (cur >= 0 && act_cnt >= p_delay) begin
      if (cur == p_err_stage) begin
        s_err[cur] = 1'b1;
        s_end[cur] = 1'b1;
      end else if (cur != p_hang_stage || exp_retry >= p_hang_tries) begin
        s_end[cur] = 1'b1;
      end
    end
  endtask

  task automatic set_policy(input int d, input int hs, input int ht, input int es);
    p_delay = d; p_hang_stage = hs; p_hang_tries = ht; p_err_stage = es;
  endtask

  // Returns the index of the first cycle (after the start edge) showing done/fail.
  task automatic run_seq(input logic [N-1:0] mask, output int t_end);
    pulses.delete();
    max_retry_seen = 0;
    skip = mask;
    en = 1'b1;
    t_end = -1;
    for (int c = 0; c < 600; c++) begin
      cycle();
      if (exp_done || exp_fail) begin
        t_end = c;
        break;
      end
    end
    check("seq_bound", 32'(exp_done || exp_fail), 1);
  endtask

  task automatic finish_seq();
    repeat (3) cycle();
    check("hold_no_restart", 32'(exp_start), 0);
    en = 1'b0;
    repeat (3) cycle();
  endtask

  initial begin
    int t;
    int n2;
    rst = 1'b1; en = 1'b0; skip = '0; s_end = '0; s_err = '0;
    cycle(); cycle();
    rst = 1'b0;
    check("rst_start", 32'(o_start), 0);
    check("rst_done_fail", 32'({o_done, o_fail}), 0);
    check("rst_idx_retry", 32'({o_idx, o_retry}), 0);
    check("rst_cause", 32'({o_fstage, o_cause}), 0);
    cycle();

    // Happy path.
    set_policy(3, -1, 0, -1);
    run_seq('0, t);
    check("happy_done", 32'(exp_done), 1);
    check("happy_fail", 32'(exp_fail), 0);
    check("happy_npulse", pulses.size(), 6);
    for (int i = 0; i < pulses.size() && i < 6; i++) check("happy_order", pulses[i], i);
    check("happy_retry", max_retry_seen, 0);
    finish_seq();

    // Skip stages 1 and 4.
    run_seq(6'b010010, t);
    check("skip_npulse", pulses.size(), 4);
    if (pulses.size() == 4) begin
      check("skip_order", 32'({pulses[0][7:0], pulses[1][7:0], pulses[2][7:0], pulses[3][7:0]}),
            32'h00020305);
    end
    check("skip_done", 32'(exp_done), 1);
    finish_seq();

    // All skipped: done rises 7 edges after the start edge.
    run_seq(6'b111111, t);
    check("allskip_latency", t, 7);
    check("allskip_npulse", pulses.size(), 0);
    finish_seq();

    // Stage 2 never ends: three attempts then timeout failure.
    set_policy(3, 2, 99, -1);
    run_seq('0, t);
    n2 = 0;
    foreach (pulses[i]) if (pulses[i] == 2) n2++;
    check("tmo_attempts", n2, 3);
    check("tmo_fail", 32'(exp_fail), 1);
    check("tmo_stage", m_fstage, 2);
    check("tmo_cause", m_fcause, 2);
    finish_seq();

    // Stage 2 ends during its second attempt.
    set_policy(3, 2, 1, -1);
    run_seq('0, t);
    check("retry_max", max_retry_seen, 1);
    check("retry_done", 32'(exp_done), 1);
    finish_seq();

    // Error and end together on stage 3.
    set_policy(3, -1, 0, 3);
    run_seq('0, t);
    check("err_fail", 32'(exp_fail), 1);
    check("err_stage", m_fstage, 3);
    check("err_cause", m_fcause, 1);
    check("err_start", 32'(exp_start), 0);
    finish_seq();

    // Abort while stage 1 is active, then restart with a fresh mask.
    set_policy(3, -1, 0, -1);
    skip = '0; en = 1'b1;
    for (int c = 0; c < 100 && !exp_start[1]; c++) cycle();
    check("abort_reach", 32'(exp_start[1]), 1);
    en = 1'b0;
    cycle(); cycle();
    check("abort_start", 32'(o_start), 0);
    check("abort_flags", 32'({o_done, o_fail, o_idx, o_retry}), 0);
    run_seq(6'b000001, t);
    check("restart_npulse", pulses.size(), 5);
    if (pulses.size() > 0) check("restart_first", pulses[0], 1);
    finish_seq();

    // Reset during stage 4.
    skip = '0; en = 1'b1;
    for (int c = 0; c < 100 && !exp_start[4]; c++) cycle();
    check("rst_reach", 32'(exp_start[4]), 1);
    rst = 1'b1; en = 1'b0;
    cycle();
    rst = 1'b0;
    check("midrst_start", 32'(o_start), 0);
    check("midrst_flags", 32'({o_done, o_fail, o_idx, o_retry, o_fstage, o_cause}), 0);
    repeat (3) begin
      cycle();
      check("midrst_nostart", 32'(o_start), 0);
    end

    // Randomized sequences with noise on other stages' bits.
    p_noise = 1'b1;
    for (int it = 0; it < 30; it++) begin
      set_policy($urandom_range(1, 18),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                 $urandom_range(0, 3),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1);
      run_seq(N'($urandom), t);
      finish_seq();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
